scr_test_sequencer: RTL and testbench
=====================================

# scr_test_sequencer

Sequencer for the CHK LE board SCR breakdown/BOD detector, on the same 50 MHz domain.
- Drives the detector's forward and negative trigger pulses and its forbid input.
- Alternates forward and negative half-cycles at a fixed period.
- After each full cycle, samples the four detector flags into a result word and counts consecutive bad cycles.
- Latches a fault, and re-forbids the detector, when a run of bad cycles reaches a limit.

## Interface
Parameters:
- PULSE_WIDTH, 500: trigger pulse high time in clocks (10 us).
- HALF_PERIOD, 1_000_000: clocks from one trigger rise to the next (20 ms). Must be ≥ 900_010 so the detector window (900_005 + 2 clocks) closes before sampling.
- ARM_CYCLES, 16: clocks with forbid released before the first pulse.
- FAIL_LIMIT, 3: consecutive bad cycles that trigger a fault. Range 1..15.

Ports (name, direction, width, meaning):
- i_clk_50m  in  1  50 MHz clock; only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  level/pulse; sampled only in IDLE.
- i_stop  in  1  pulse; graceful stop request.
- i_abort  in  1  level; immediate abort.
- i_clear  in  1  pulse; clears fault.
- i_fwd_state, i_neg_state, i_fwd_bod, i_neg_bod  in  1 each  detector flags; 1 = action.
- o_trig_forward  out  1  forward trigger to detector.
- o_trig_negative  out  1  negative trigger to detector.
- o_signal_forbid  out  1  detector forbid; 1 = inhibit.
- o_busy  out  1  high in every state except IDLE and FAULT.
- o_result_valid  out  1  one-clock strobe.
- o_result  out  4  {neg_bod, fwd_bod, neg_state, fwd_state}.
- o_fault  out  1  latched fault.
- o_cycle_cnt  out  16  completed cycles, saturating.

## Operation
States: IDLE, ARM, FWD_PULSE, FWD_WAIT, NEG_PULSE, NEG_WAIT, EVAL, FAULT.
- IDLE: forbid = 1, triggers = 0.
  - i_start = 1 → ARM.
  - o_cycle_cnt and the bad-cycle counter clear on that transition.
  - The stop latch also clears on that transition.
- ARM: forbid = 0 for ARM_CYCLES clocks → FWD_PULSE.
- FWD_PULSE: o_trig_forward = 1 for PULSE_WIDTH clocks → FWD_WAIT.
  - The 20-bit phase counter restarts at 0 on entry.
- FWD_WAIT: triggers = 0 until the phase counter reaches HALF_PERIOD-1 → NEG_PULSE.
- NEG_PULSE / NEG_WAIT: same as the forward pair, using o_trig_negative.
- EVAL (one clock):
  - Register o_result from the inputs and pulse o_result_valid.
  - Increment o_cycle_cnt, saturating at 0xFFFF.
- Bad-cycle counter (4-bit):
  - o_result != 0 → increment, saturating at 15.
  - o_result == 0 → clear to 0.
- Next state after EVAL, by priority:
  1. New bad-cycle count ≥ FAIL_LIMIT → FAULT.
  2. Stop latch set → IDLE.
  3. Otherwise → FWD_PULSE.
- FAULT: forbid = 1, triggers = 0, o_fault = 1.
  - i_clear → IDLE with o_fault = 0.
  - i_start is ignored in FAULT.
- i_stop pulse while o_busy sets the stop latch. The current cycle completes, including EVAL.
- i_abort = 1 in any busy state:
  - Next clock → IDLE with triggers = 0 and forbid = 1.
  - No o_result_valid; o_result holds its last value.
  - In IDLE, i_abort blocks i_start.
- Forward and negative triggers are never high in the same clock.

## Timing
- All outputs are registered.
- Reset values: forbid = 1; o_trig_forward = 0; o_trig_negative = 0; o_busy = 0; o_result_valid = 0; o_result = 0; o_fault = 0; o_cycle_cnt = 0; state = IDLE.
- Reset mid-operation takes effect on the next edge and overrides everything.
- Latency from i_start sampled high:
  - forbid falls 1 clock later;
  - o_trig_forward rises ARM_CYCLES+1 clocks later.
- Pulse timing:
  - The forward rise precedes the negative rise by exactly HALF_PERIOD clocks.
  - Each pulse is exactly PULSE_WIDTH clocks high.
- Cycle length, rise to rise of o_trig_forward: 2·HALF_PERIOD + 1 clocks, the extra clock being EVAL.
- In EVAL, o_result is registered and o_result_valid is high in the same clock, i.e. the strobe's clock.
- Simultaneous events:
  - i_abort beats i_stop.
  - A fault reached in EVAL beats the stop latch.
  - i_clear outside FAULT has no effect.

## Test plan
The bench uses a behavioral detector model and PULSE_WIDTH=4, HALF_PERIOD=40, ARM_CYCLES=2, FAIL_LIMIT=3; the HALF_PERIOD ≥ 900_010 constraint is waived for the bench only.
- Clean run:
  - Stimulus: i_start, model returns flags 0.
  - Required: forward rise 3 clocks after start; negative rise 40 clocks later; o_result_valid every 81 clocks with o_result = 0; o_cycle_cnt = 1, 2, 3.
- Fault:
  - Stimulus: model returns fwd_bod = 1 every cycle.
  - Required: o_result = 4'b0100 three times, then FAULT with o_fault = 1 and forbid = 1.
  - Then: i_clear → IDLE, o_fault = 0.
- Non-consecutive bad cycles:
  - Stimulus: pattern bad, bad, good, bad, bad.
  - Required: no fault (counter reset by the good cycle).
- Graceful stop:
  - Stimulus: i_stop during NEG_PULSE of cycle 2.
  - Required: cycle 2 EVAL strobes, then IDLE; no further triggers; o_cycle_cnt = 2.
- Abort:
  - Stimulus: i_abort at FWD_WAIT clock 10.
  - Required: next clock triggers = 0, forbid = 1, o_busy = 0, no strobe.
- Reset:
  - Stimulus: i_rst during an active trigger pulse.
  - Required: all outputs at reset values next clock.

Source files
------------

// File: rtl/scr_test_sequencer_if.sv
// Control, status and detector-side signals of the SCR test sequencer.
// The master modport is the sequencer; the slave modport is the host/detector side.
interface scr_test_sequencer_if;
  logic        i_start;
  logic        i_stop;
  logic        i_abort;
  logic        i_clear;
  logic        i_fwd_state;
  logic        i_neg_state;
  logic        i_fwd_bod;
  logic        i_neg_bod;
  logic        o_trig_forward;
  logic        o_trig_negative;
  logic        o_signal_forbid;
  logic        o_busy;
  logic        o_result_valid;
  logic [3:0]  o_result;
  logic        o_fault;
  logic [15:0] o_cycle_cnt;

  modport master (
    input  i_start, i_stop, i_abort, i_clear,
    input  i_fwd_state, i_neg_state, i_fwd_bod, i_neg_bod,
    output o_trig_forward, o_trig_negative, o_signal_forbid, o_busy,
    output o_result_valid, o_result, o_fault, o_cycle_cnt
  );

  modport slave (
    output i_start, i_stop, i_abort, i_clear,
    output i_fwd_state, i_neg_state, i_fwd_bod, i_neg_bod,
    input  o_trig_forward, o_trig_negative, o_signal_forbid, o_busy,
    input  o_result_valid, o_result, o_fault, o_cycle_cnt
  );
endinterface

// File: rtl/scr_test_sequencer.sv
// SCR breakdown/BOD detector test sequencer: alternating forward/negative trigger
// half-cycles, per-cycle flag sampling, consecutive-bad-cycle fault latch.
module scr_test_sequencer #(
  parameter int PULSE_WIDTH = 500,
  parameter int HALF_PERIOD = 1_000_000,
  parameter int ARM_CYCLES  = 16,
  parameter int FAIL_LIMIT  = 3
) (
  input logic                  i_clk_50m,
  input logic                  i_rst,
  scr_test_sequencer_if.master seq
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_FWD_PULSE = 3'd2;
  localparam logic [2:0] S_FWD_WAIT  = 3'd3;
  localparam logic [2:0] S_NEG_PULSE = 3'd4;
  localparam logic [2:0] S_NEG_WAIT  = 3'd5;
  localparam logic [2:0] S_EVAL      = 3'd6;
  localparam logic [2:0] S_FAULT     = 3'd7;

  localparam logic [19:0] ARM_LAST = 20'(ARM_CYCLES - 1);
  localparam logic [19:0] PW_LAST  = 20'(PULSE_WIDTH - 1);
  localparam logic [19:0] HP_LAST  = 20'(HALF_PERIOD - 1);
  localparam logic [3:0]  LIMIT    = 4'(FAIL_LIMIT);

  logic [2:0]  state, state_nxt;
  logic [19:0] phase;
  logic [3:0]  bad_cnt, bad_nxt;
  logic [3:0]  flags;
  logic        stop_latch;
  logic        busy_st, abort_now, stop_req, phase_rst;

  assign flags     = {seq.i_neg_bod, seq.i_fwd_bod, seq.i_neg_state, seq.i_fwd_state};
  assign busy_st   = (state != S_IDLE) && (state != S_FAULT);
  assign abort_now = busy_st && seq.i_abort;
  assign stop_req  = stop_latch || seq.i_stop;
  assign bad_nxt   = (flags == 4'd0) ? 4'd0 :
                     (bad_cnt == 4'hF) ? bad_cnt : bad_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (seq.i_start && !seq.i_abort) state_nxt = S_ARM;
      S_ARM:       if (phase == ARM_LAST) state_nxt = S_FWD_PULSE;
      S_FWD_PULSE: if (phase == PW_LAST)  state_nxt = S_FWD_WAIT;
      S_FWD_WAIT:  if (phase == HP_LAST)  state_nxt = S_NEG_PULSE;
      S_NEG_PULSE: if (phase == PW_LAST)  state_nxt = S_NEG_WAIT;
      S_NEG_WAIT:  if (phase == HP_LAST)  state_nxt = S_EVAL;
      S_EVAL: begin
        if (bad_nxt >= LIMIT) state_nxt = S_FAULT;
        else if (stop_req)    state_nxt = S_IDLE;
        else                  state_nxt = S_FWD_PULSE;
      end
      S_FAULT:     if (seq.i_clear) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (abort_now) state_nxt = S_IDLE;
  end

  // The phase counter runs across a pulse and its wait so one half-cycle is
  // measured rise to rise; it restarts only when a pulse (or ARM) is entered.
  assign phase_rst = (state_nxt != state) &&
                     ((state_nxt == S_ARM) || (state_nxt == S_FWD_PULSE) ||
                      (state_nxt == S_NEG_PULSE));

  // Outputs are decoded from the current state into flops, so they trail the
  // state register by one clock; abort forces them idle at the same edge.
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state               <= S_IDLE;
      phase               <= '0;
      bad_cnt             <= '0;
      stop_latch          <= 1'b0;
      seq.o_trig_forward  <= 1'b0;
      seq.o_trig_negative <= 1'b0;
      seq.o_signal_forbid <= 1'b1;
      seq.o_busy          <= 1'b0;
      seq.o_result_valid  <= 1'b0;
      seq.o_result        <= '0;
      seq.o_fault         <= 1'b0;
      seq.o_cycle_cnt     <= '0;
    end else begin
      state               <= state_nxt;
      phase               <= phase_rst ? 20'd0 : phase + 20'd1;
      seq.o_trig_forward  <= (state == S_FWD_PULSE) && !abort_now;
      seq.o_trig_negative <= (state == S_NEG_PULSE) && !abort_now;
      seq.o_signal_forbid <= !busy_st || abort_now;
      seq.o_busy          <= busy_st && !abort_now;
      seq.o_result_valid  <= (state == S_EVAL) && !abort_now;
      seq.o_fault         <= (state == S_FAULT);

      if ((state == S_EVAL) && !abort_now) begin
        seq.o_result    <= flags;
        bad_cnt         <= bad_nxt;
        seq.o_cycle_cnt <= (seq.o_cycle_cnt == 16'hFFFF) ? seq.o_cycle_cnt
                                                         : seq.o_cycle_cnt + 16'd1;
      end

      if ((state == S_IDLE) && (state_nxt == S_ARM)) begin
        seq.o_cycle_cnt <= '0;
        bad_cnt         <= '0;
        stop_latch      <= 1'b0;
      end else if (busy_st && seq.i_stop) begin
        stop_latch <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scr_test_sequencer.sv
// Scoreboard bench for scr_test_sequencer with a behavioural detector model.
`timescale 1ns/1ps
module tb_scr_test_sequencer;
  localparam int PW  = 4;
  localparam int HP  = 40;
  localparam int ARM = 2;
  localparam int LIM = 3;
  localparam int CL  = 2 * HP + 1;

  typedef struct {
    logic [3:0] res;
    int         cnt;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_strobe = 0;
  int   n_fwd_rise = 0;
  int   last_fwd_rise = -1000;
  int   last_neg_rise = -1000;
  int   last_forbid_fall = -1;
  bit   pw_en = 1'b1;
  logic pf = 1'b0, pn = 1'b0, pfb = 1'b1;
  logic [3:0] last_res = 4'd0;
  logic [3:0] det_flags = 4'd0;
  logic [3:0] det_q[$];
  logic [3:0] pq[$];
  exp_t exp_q[$];
  exp_t e_mon;

  scr_test_sequencer_if ifc();

  scr_test_sequencer #(
    .PULSE_WIDTH(PW), .HALF_PERIOD(HP), .ARM_CYCLES(ARM), .FAIL_LIMIT(LIM)
  ) dut (
    .i_clk_50m(clk),
    .i_rst    (rst),
    .seq      (ifc)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ifc.i_fwd_state = det_flags[0];
  assign ifc.i_neg_state = det_flags[1];
  assign ifc.i_fwd_bod   = det_flags[2];
  assign ifc.i_neg_bod   = det_flags[3];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Detector model: presents this cycle's flags until the sequencer samples them.
  always @(negedge clk) begin
    if (ifc.o_result_valid && det_q.size() > 0) void'(det_q.pop_front());
    det_flags = (det_q.size() > 0) ? det_q[0] : 4'd0;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (ifc.o_result_valid) begin
      n_strobe++;
      if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e_mon = exp_q.pop_front();
        chk("result", int'(ifc.o_result), int'(e_mon.res));
        chk("cycle_cnt", int'(ifc.o_cycle_cnt), e_mon.cnt);
        chk("strobe_time", cyc, e_mon.at);
      end
    end
  end

  // Trigger timing monitor
  always @(negedge clk) begin
    if (!rst) chk("trig_exclusive", int'(ifc.o_trig_forward & ifc.o_trig_negative), 0);
    if (ifc.o_trig_forward === 1'b1 && !pf) begin
      last_fwd_rise = cyc;
      n_fwd_rise++;
    end
    if (ifc.o_trig_forward === 1'b0 && pf && pw_en) chk("fwd_width", cyc - last_fwd_rise, PW);
    if (ifc.o_trig_negative === 1'b1 && !pn) begin
      last_neg_rise = cyc;
      chk("neg_after_fwd", cyc - last_fwd_rise, HP);
    end
    if (ifc.o_trig_negative === 1'b0 && pn && pw_en) chk("neg_width", cyc - last_neg_rise, PW);
    if (ifc.o_signal_forbid === 1'b0 && pfb) last_forbid_fall = cyc;
    pf  = (ifc.o_trig_forward === 1'b1);
    pn  = (ifc.o_trig_negative === 1'b1);
    pfb = (ifc.o_signal_forbid !== 1'b0);
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    int g = 0;
    while (cyc < t && g < 20000) begin @(negedge clk); g++; end
  endtask

  task automatic wait_strobes(input int k);
    int g = 0;
    while (n_strobe < k && g < 1000) begin @(negedge clk); g++; end
    if (n_strobe < k) chk("strobe_timeout", n_strobe, k);
  endtask

  task automatic pulse_start(output int s);
    s = cyc + 1;
    ifc.i_start = 1'b1;
    @(negedge clk);
    ifc.i_start = 1'b0;
  endtask

  // Run pq as per-cycle detector flags; request stop in cycle stop_cyc at
  // stop_off clocks into it. The model predicts strobes and the fault outcome.
  task automatic do_run(input int stop_cyc, input int stop_off);
    int s, run, n_exp, base, rises;
    bit fault;
    logic [3:0] f;
    exp_t e;
    run = 0; n_exp = 0; fault = 1'b0; base = n_strobe;
    s = cyc + 1;
    for (int i = 0; i < stop_cyc && !fault; i++) begin
      f = (i < pq.size()) ? pq[i] : 4'd0;
      e.res = f;
      e.cnt = i + 1;
      e.at  = s + ARM + 1 + 2 * HP + i * CL;
      exp_q.push_back(e);
      last_res = f;
      run   = (f != 4'd0) ? run + 1 : 0;
      n_exp = i + 1;
      if (run >= LIM) fault = 1'b1;
    end
    det_q = pq;
    pulse_start(s);
    wait_cyc(s + ARM + 2);
    chk("forbid_fall", last_forbid_fall, s + 1);
    chk("fwd_first_rise", last_fwd_rise, s + ARM + 1);
    if (!(fault && n_exp < stop_cyc)) begin
      wait_cyc(s + ARM + (stop_cyc - 1) * CL + stop_off - 1);
      ifc.i_stop = 1'b1;
      @(negedge clk);
      ifc.i_stop = 1'b0;
    end
    wait_strobes(base + n_exp);
    rises = n_fwd_rise;
    clk_n(3);
    chk("fault", int'(ifc.o_fault), int'(fault));
    chk("busy_after", int'(ifc.o_busy), 0);
    chk("forbid_after", int'(ifc.o_signal_forbid), 1);
    chk("cnt_after", int'(ifc.o_cycle_cnt), n_exp);
    if (fault) begin
      ifc.i_start = 1'b1;
      clk_n(3);
      ifc.i_start = 1'b0;
      chk("start_ignored_in_fault", int'(ifc.o_busy), 0);
      ifc.i_clear = 1'b1;
      @(negedge clk);
      ifc.i_clear = 1'b0;
      clk_n(2);
      chk("fault_cleared", int'(ifc.o_fault), 0);
    end
    clk_n(CL);
    chk("no_trig_after_end", n_fwd_rise, rises);
    chk("queue_drained", exp_q.size(), 0);
    det_q.delete();
  endtask

  task automatic mk(input int n, input logic [3:0] a, b, c, d, f);
    logic [3:0] v[5];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = f;
    pq.delete();
    for (int i = 0; i < n; i++) pq.push_back(v[i]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_forbid"}, int'(ifc.o_signal_forbid), 1);
    chk({tag, "_fwd"}, int'(ifc.o_trig_forward), 0);
    chk({tag, "_neg"}, int'(ifc.o_trig_negative), 0);
    chk({tag, "_busy"}, int'(ifc.o_busy), 0);
    chk({tag, "_valid"}, int'(ifc.o_result_valid), 0);
    chk({tag, "_result"}, int'(ifc.o_result), 0);
    chk({tag, "_fault"}, int'(ifc.o_fault), 0);
    chk({tag, "_cnt"}, int'(ifc.o_cycle_cnt), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, len, rises;
    logic [3:0] hold;
    ifc.i_start = 1'b0; ifc.i_stop = 1'b0; ifc.i_abort = 1'b0; ifc.i_clear = 1'b0;
    rst = 1'b1;
    clk_n(3);
    rst = 1'b0;
    chk_reset_vals("reset");

    // Clean run, fault run, then a reset landing inside a trigger pulse.
    mk(3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);  do_run(3, 10);
    mk(5, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4);  do_run(5, 10);

    det_q.delete();
    pulse_start(s);
    wait_cyc(s + ARM + 2);
    chk("trig_high_before_rst", int'(ifc.o_trig_forward), 1);
    pw_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    last_res = 4'd0;
    clk_n(2);
    pw_en = 1'b1;
    rises = n_fwd_rise;
    clk_n(CL);
    chk("idle_after_rst", n_fwd_rise, rises);

    // Non-consecutive bad cycles, then graceful stop in NEG_PULSE of cycle 2.
    mk(5, 4'd4, 4'd4, 4'd0, 4'd4, 4'd4);  do_run(5, 20);
    mk(4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);  do_run(2, HP + 2);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 6);
      pq.delete();
      for (int i = 0; i < len; i++)
        pq.push_back(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
      do_run(len, $urandom_range(4, 2 * HP));
    end

    // Abort at FWD_WAIT clock 10, with a simultaneous stop request.
    hold = last_res;
    det_q.delete();
    det_q.push_back(4'd0);
    pulse_start(s);
    wait_cyc(s + ARM + PW + 9);
    ifc.i_abort = 1'b1;
    ifc.i_stop  = 1'b1;
    @(negedge clk);
    ifc.i_abort = 1'b0;
    ifc.i_stop  = 1'b0;
    chk("abort_fwd", int'(ifc.o_trig_forward), 0);
    chk("abort_neg", int'(ifc.o_trig_negative), 0);
    chk("abort_forbid", int'(ifc.o_signal_forbid), 1);
    chk("abort_busy", int'(ifc.o_busy), 0);
    chk("abort_valid", int'(ifc.o_result_valid), 0);
    rises = n_fwd_rise;
    clk_n(2 * CL);
    chk("abort_no_trig", n_fwd_rise, rises);
    chk("abort_result_held", int'(ifc.o_result), int'(hold));
    det_q.delete();

    // Abort held in IDLE blocks start.
    ifc.i_abort = 1'b1;
    ifc.i_start = 1'b1;
    clk_n(3);
    ifc.i_start = 1'b0;
    ifc.i_abort = 1'b0;
    clk_n(2);
    chk("abort_blocks_start_busy", int'(ifc.o_busy), 0);
    chk("abort_blocks_start_forbid", int'(ifc.o_signal_forbid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
